saradc_sar_ctrl: RTL
====================

// Module: saradc_sar_ctrl
// PURPOSE
//  Successive-approximation controller for the sg13g2 SAR ADC. Sequences sampling switch,
//  comparator strobe and capacitive-DAC trial bits, builds the NBITS result MSB-first and
//  hands it off through a one-entry valid/ready output buffer. Sits between the digital host
//  and the SARADC_CELL_* analog-facing drivers (DAC buffers, comparator clock gating).
// PARAMETERS
//  NBITS    8  resolution; DAC/DATA width (2..16)
//  TSAMPLE  4  cycles SAMPLE held high (1..255)
//  TSETTLE  1  DAC settle cycles before each strobe (1..15)
// PORTS
//  CLK         in   1      single clock; all state on rising edge
//  RSTN        in   1      asynchronous, active-low reset
//  START       in   1      conversion request; accepted only in IDLE
//  COMP        in   1      comparator decision, 1 = Vin >= Vdac; sampled at end of CMP cycle
//  SAMPLE      out  1      sampling switch enable
//  COMP_STB    out  1      comparator latch strobe
//  DAC         out  NBITS  DAC trial code
//  BUSY        out  1      high in every state except IDLE
//  DATA        out  NBITS  conversion result
//  DATA_VALID  out  1      DATA holds an unconsumed result
//  DATA_READY  in   1      consumer accepts DATA when DATA_VALID & DATA_READY
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): state=IDLE; SAMPLE=0, COMP_STB=0, DAC=0, BUSY=0,
//   DATA=0, DATA_VALID=0; counters cleared. Mid-conversion reset aborts; no partial result.
//  FSM: IDLE -> SAMP -> SETTLE -> CMP -> (SETTLE|WAIT|IDLE).
//   IDLE:   START=1 -> SAMP next cycle. SAMPLE=1 for exactly TSAMPLE cycles.
//   SAMP->SETTLE: bit index k=NBITS-1; DAC = trial with bit k set, lower bits 0.
//   SETTLE: TSETTLE cycles, DAC stable, COMP_STB=0.
//   CMP:    one cycle COMP_STB=1; at its end bit k := COMP; k>0 -> k-1, set trial bit k-1,
//           -> SETTLE; k==0 -> result complete.
//  Latency START to DATA_VALID: 1 + TSAMPLE + NBITS*(TSETTLE+1) cycles (8b default: 21).
//  Completion: buffer empty, or DATA_VALID&DATA_READY same cycle -> load DATA, DATA_VALID=1,
//   -> IDLE. Otherwise -> WAIT (BUSY=1, DAC holds final code) until buffer frees, then load.
//  Handshake: DATA stable while DATA_VALID=1 and not accepted; DATA_VALID falls the cycle
//   after acceptance unless a new result loads in that same cycle (stays 1, DATA updates).
//  START while BUSY ignored (not queued). START in IDLE while DATA_VALID=1 is accepted.
//  Simultaneous START and completion: IDLE entered first; START must be reasserted.
//  DAC after completion holds final code until next SAMP entry; DAC=0 during SAMP.
//  All-ones and all-zeros inputs reach DATA=2^NBITS-1 and 0 without wrap.
// CONFIGURATION
//  SARADC_CTRL_AUTOREPEAT_EN defined: extra input CONT (1b). With CONT=1 the FSM re-enters
//   SAMP directly after loading a result (no IDLE cycle, BUSY stays 1); WAIT still applies.
//   CONT=0 behaves as base block.
//  Not defined: no CONT port; one conversion per START.
// STRUCTURE
//  saradc_pkg: state enum (IDLE,SAMP,SETTLE,CMP,WAIT), default NBITS/TSAMPLE/TSETTLE
//   localparams, bit-index width function clog2.
//  Sub-module saradc_sar_reg: NBITS trial/result register with load-trial(k), decide(k,COMP),
//   clear; FSM, timers and output buffer stay in saradc_sar_ctrl.
// TESTING
//  1 Defaults, comparator model Vin=0xA5, READY=1: START -> DATA=0xA5, DATA_VALID at cycle 21.
//  2 Vin=0xFF then 0x00: DATA=0xFF / 0x00; DAC trial sequence 0x80,0xC0..0xFF checked.
//  3 READY=0 after result 1, START again: FSM holds WAIT, DATA stays result 1; READY=1 ->
//    result 2 loaded same cycle, DATA_VALID stays 1.
//  4 START pulses during SAMP/CMP: ignored, single conversion, latency unchanged.
//  5 RSTN low in CMP of bit 3: all outputs reset immediately; next START yields correct code.
//  6 AUTOREPEAT_EN, CONT=1, READY=1: back-to-back results every 20 cycles, BUSY never drops.

Source files
------------

// File: rtl/saradc_pkg.sv
// saradc_pkg: shared FSM state codes, default sizing and a width helper for the SAR controller.
`default_nettype none

package saradc_pkg;

  localparam int SAR_NBITS_DEF   = 8;
  localparam int SAR_TSAMPLE_DEF = 4;
  localparam int SAR_TSETTLE_DEF = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMP   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CMP    = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;

  // Bits needed to index 0..v-1; never returns less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/saradc_sar_reg.sv
// saradc_sar_reg: successive-approximation trial/result register (clear, load-trial, decide).
`default_nettype none

module saradc_sar_reg
  import saradc_pkg::*;
#(
  parameter int NBITS = SAR_NBITS_DEF,
  parameter int KW    = clog2(NBITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load_trial,
  input  logic             decide,
  input  logic [KW-1:0]    idx,
  input  logic             comp,
  output logic [NBITS-1:0] code
);

  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  // Priority clear > load > decide lets a restart override the final decision write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
    end else if (clear) begin
      code <= '0;
    end else if (load_trial) begin
      code <= ONE << idx;
    end else if (decide) begin
      code[idx] <= comp;
      if (idx != '0) code[idx - KW'(1)] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/saradc_sar_ctrl.sv
// saradc_sar_ctrl: SAR ADC sequencer with one-entry valid/ready result buffer.
// Optional SARADC_CTRL_AUTOREPEAT_EN adds the CONT input for back-to-back conversions.
`default_nettype none

module saradc_sar_ctrl
  import saradc_pkg::*;
#(
  parameter int NBITS   = SAR_NBITS_DEF,
  parameter int TSAMPLE = SAR_TSAMPLE_DEF,
  parameter int TSETTLE = SAR_TSETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             comp,
`ifdef SARADC_CTRL_AUTOREPEAT_EN
  input  logic             cont,
`endif
  output logic             sample,
  output logic             comp_stb,
  output logic [NBITS-1:0] dac,
  output logic             busy,
  output logic [NBITS-1:0] data,
  output logic             data_valid,
  input  logic             data_ready
);

  localparam int            KW    = clog2(NBITS);
  localparam logic [KW-1:0] K_MSB = KW'(NBITS - 1);
  localparam logic [7:0]    T_SMP = 8'(TSAMPLE - 1);
  localparam logic [7:0]    T_STL = 8'(TSETTLE - 1);

  logic [2:0]       state, state_nx;
  logic [7:0]       timer;
  logic [KW-1:0]    bit_idx;
  logic [NBITS-1:0] code, result;
  logic             buf_free, load_buf, cont_en;
  logic             reg_clear, reg_load, reg_decide;

`ifdef SARADC_CTRL_AUTOREPEAT_EN
  assign cont_en = cont;
`else
  assign cont_en = 1'b0;
`endif

  assign buf_free = !data_valid || data_ready;

  always_comb begin
    result    = code;
    result[0] = comp;
  end

  always_comb begin
    state_nx = state;
    load_buf = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_SAMP;
      ST_SAMP:   if (timer == '0) state_nx = ST_SETTLE;
      ST_SETTLE: if (timer == '0) state_nx = ST_CMP;
      ST_CMP: begin
        if (bit_idx != '0) begin
          state_nx = ST_SETTLE;
        end else if (buf_free) begin
          load_buf = 1'b1;
          state_nx = cont_en ? ST_SAMP : ST_IDLE;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (buf_free) begin
          load_buf = 1'b1;
          state_nx = cont_en ? ST_SAMP : ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // DAC is cleared only on SAMP entry, so the final code stays visible while idle or waiting.
  assign reg_clear  = (state_nx == ST_SAMP) && (state != ST_SAMP);
  assign reg_load   = (state == ST_SAMP) && (state_nx == ST_SETTLE);
  assign reg_decide = (state == ST_CMP);

  saradc_sar_reg #(
    .NBITS (NBITS),
    .KW    (KW)
  ) u_sar_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (reg_clear),
    .load_trial (reg_load),
    .decide     (reg_decide),
    .idx        (reg_load ? K_MSB : bit_idx),
    .comp       (comp),
    .code       (code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      state <= state_nx;

      if ((state_nx == ST_SAMP) && (state != ST_SAMP))
        timer <= T_SMP;
      else if ((state_nx == ST_SETTLE) && (state != ST_SETTLE))
        timer <= T_STL;
      else if (timer != '0)
        timer <= timer - 8'd1;

      if (reg_load)
        bit_idx <= K_MSB;
      else if ((state == ST_CMP) && (bit_idx != '0))
        bit_idx <= bit_idx - KW'(1);

      // WAIT reads the register, which already holds the decided LSB.
      if (load_buf) begin
        data       <= (state == ST_CMP) ? result : code;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign sample   = (state == ST_SAMP);
  assign comp_stb = (state == ST_CMP);
  assign busy     = (state != ST_IDLE);
  assign dac      = code;

endmodule

`default_nettype wire
